// File: rtl/sdram_burst_fifo.sv
// sdram_burst_fifo: user-side front end for the SDRAM data stage.
// A write FIFO feeds BL-word write bursts with auto-incrementing start addresses.
// A read prefetcher issues BL-word read bursts into a read FIFO that is presented
// as a show-ahead user read stream. Both address pointers wrap inside
// [ADDR_BASE, ADDR_BASE+ADDR_LEN).
module sdram_burst_fifo #(
  parameter int DW        = 16,
  parameter int AW        = 24,
  parameter int BL        = 4,
  parameter int WF_DEPTH  = 16,
  parameter int RF_DEPTH  = 16,
  parameter int ADDR_BASE = 0,
  parameter int ADDR_LEN  = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DW-1:0]                 us_wr_data,
  input  logic                          us_wr_valid,
  output logic                          us_wr_ready,
  output logic [DW-1:0]                 us_rd_data,
  output logic                          us_rd_valid,
  input  logic                          us_rd_ready,
  input  logic                          rd_en,
  input  logic                          wr_addr_clr,
  input  logic                          rd_addr_clr,
  output logic [DW-1:0]                 wr_data,
  output logic [AW-1:0]                 wr_addr,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [AW-1:0]                 rd_addr,
  output logic                          rd_avalid,
  input  logic                          rd_aready,
  input  logic [DW-1:0]                 rd_data,
  input  logic                          rd_valid,
  output logic                          rd_ready,
  output logic [$clog2(WF_DEPTH):0]     wf_level,
  output logic [$clog2(RF_DEPTH):0]     rf_level
);

  localparam int WPW = $clog2(WF_DEPTH);
  localparam int RPW = $clog2(RF_DEPTH);
  localparam int WLW = WPW + 1;
  localparam int RLW = RPW + 1;
  localparam int BCW = (BL > 1) ? $clog2(BL) : 1;
  localparam logic [AW-1:0]  A_BASE = AW'(ADDR_BASE);
  localparam logic [AW-1:0]  A_END  = AW'(ADDR_BASE + ADDR_LEN);
  localparam logic [AW-1:0]  A_BL   = AW'(BL);
  localparam logic [BCW-1:0] B_LAST = BCW'(BL - 1);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_BURST = 1'b1} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rstate_t;

  // Next burst start address; landing exactly on the window end wraps to the base.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a + A_BL;
    if (s == A_END) return A_BASE;
    else            return s;
  endfunction

  // ---------------- write FIFO ----------------
  logic [DW-1:0]  wf_mem_r [WF_DEPTH];
  logic [WPW-1:0] wf_wp_r, wf_rp_r;
  logic [WLW-1:0] wf_level_r, wf_level_nxt_s;
  logic           wf_ready_r, wf_push_s, wf_pop_s;

  wstate_t        w_state_r, w_state_nxt_s;
  logic [BCW-1:0] w_beat_r;
  logic [AW-1:0]  w_addr_r;
  logic           w_clr_pend_r, w_clr_eff_s;

  assign wf_push_s   = us_wr_valid && wf_ready_r;
  assign wf_pop_s    = (w_state_r == W_BURST) && wr_ready;
  assign w_clr_eff_s = w_clr_pend_r || wr_addr_clr;

  // Write FIFO occupancy after this cycle's push/pop.
  always_comb begin
    wf_level_nxt_s = wf_level_r;
    case ({wf_push_s, wf_pop_s})
      2'b10:   wf_level_nxt_s = wf_level_r + WLW'(1);
      2'b01:   wf_level_nxt_s = wf_level_r - WLW'(1);
      default: wf_level_nxt_s = wf_level_r;
    endcase
  end

  // Write FIFO storage; contents are don't-care once the pointers reset.
  always_ff @(posedge clk) begin
    if (wf_push_s) wf_mem_r[wf_wp_r] <= us_wr_data;
  end

  // Write FIFO pointers, level and registered not-full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wf_wp_r    <= {WPW{1'b0}};
      wf_rp_r    <= {WPW{1'b0}};
      wf_level_r <= {WLW{1'b0}};
      wf_ready_r <= 1'b0;
    end else begin
      if (wf_push_s) wf_wp_r <= wf_wp_r + WPW'(1);
      if (wf_pop_s)  wf_rp_r <= wf_rp_r + WPW'(1);
      wf_level_r <= wf_level_nxt_s;
      wf_ready_r <= (wf_level_nxt_s != WLW'(WF_DEPTH));
    end
  end

  // Write FSM next state; a pending clear holds IDLE for the cycle it is applied.
  always_comb begin
    w_state_nxt_s = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if (w_clr_eff_s)                     w_state_nxt_s = W_IDLE;
        else if (wf_level_r >= WLW'(BL))     w_state_nxt_s = W_BURST;
        else                                 w_state_nxt_s = W_IDLE;
      end
      W_BURST: begin
        if (wf_pop_s && (w_beat_r == B_LAST)) w_state_nxt_s = W_IDLE;
        else                                  w_state_nxt_s = W_BURST;
      end
      default: w_state_nxt_s = W_IDLE;
    endcase
  end

  // Write FSM state, beat counter, address pointer and pending clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_r    <= W_IDLE;
      w_beat_r     <= {BCW{1'b0}};
      w_addr_r     <= A_BASE;
      w_clr_pend_r <= 1'b0;
    end else begin
      w_state_r <= w_state_nxt_s;
      case (w_state_r)
        W_IDLE: begin
          w_beat_r <= {BCW{1'b0}};
          if (w_clr_eff_s) begin
            w_addr_r     <= A_BASE;
            w_clr_pend_r <= 1'b0;
          end
        end
        W_BURST: begin
          if (wr_addr_clr) w_clr_pend_r <= 1'b1;
          if (wf_pop_s) begin
            if (w_beat_r == B_LAST) begin
              w_beat_r <= {BCW{1'b0}};
              w_addr_r <= next_addr(w_addr_r);
            end else begin
              w_beat_r <= w_beat_r + BCW'(1);
            end
          end
        end
        default: w_beat_r <= {BCW{1'b0}};
      endcase
    end
  end

  assign us_wr_ready = wf_ready_r;
  assign wf_level    = wf_level_r;
  assign wr_valid    = (w_state_r == W_BURST);
  assign wr_addr     = w_addr_r;
  assign wr_data     = wf_mem_r[wf_rp_r];

  // ---------------- read FIFO ----------------
  logic [DW-1:0]  rf_mem_r [RF_DEPTH];
  logic [RPW-1:0] rf_wp_r, rf_rp_r;
  logic [RLW-1:0] rf_level_r;
  logic           rf_push_s, rf_pop_s, rf_flush_s;

  rstate_t        r_state_r, r_state_nxt_s;
  logic [BCW-1:0] r_beat_r;
  logic [AW-1:0]  r_addr_r;
  logic           r_clr_pend_r, r_clr_eff_s, r_space_s;

  assign rf_push_s   = (r_state_r == R_DATA) && rd_valid;
  assign rf_pop_s    = (rf_level_r != {RLW{1'b0}}) && us_rd_ready;
  assign r_clr_eff_s = r_clr_pend_r || rd_addr_clr;
  assign rf_flush_s  = (r_state_r == R_IDLE) && r_clr_eff_s;
  assign r_space_s   = ((RLW'(RF_DEPTH) - rf_level_r) >= RLW'(BL));

  // Read FIFO storage.
  always_ff @(posedge clk) begin
    if (rf_push_s) rf_mem_r[rf_wp_r] <= rd_data;
  end

  // Read FIFO pointers and level; a flush discards any same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst || rf_flush_s) begin
      rf_wp_r    <= {RPW{1'b0}};
      rf_rp_r    <= {RPW{1'b0}};
      rf_level_r <= {RLW{1'b0}};
    end else begin
      if (rf_push_s) rf_wp_r <= rf_wp_r + RPW'(1);
      if (rf_pop_s)  rf_rp_r <= rf_rp_r + RPW'(1);
      case ({rf_push_s, rf_pop_s})
        2'b10:   rf_level_r <= rf_level_r + RLW'(1);
        2'b01:   rf_level_r <= rf_level_r - RLW'(1);
        default: rf_level_r <= rf_level_r;
      endcase
    end
  end

  // Read FSM next state; a burst only starts once BL words of space are free.
  always_comb begin
    r_state_nxt_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (r_clr_eff_s)              r_state_nxt_s = R_IDLE;
        else if (rd_en && r_space_s)  r_state_nxt_s = R_ADDR;
        else                          r_state_nxt_s = R_IDLE;
      end
      R_ADDR: begin
        if (rd_aready) r_state_nxt_s = R_DATA;
        else           r_state_nxt_s = R_ADDR;
      end
      R_DATA: begin
        if (rd_valid && (r_beat_r == B_LAST)) r_state_nxt_s = R_IDLE;
        else                                  r_state_nxt_s = R_DATA;
      end
      default: r_state_nxt_s = R_IDLE;
    endcase
  end

  // Read FSM state, beat counter, address pointer and pending clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_r    <= R_IDLE;
      r_beat_r     <= {BCW{1'b0}};
      r_addr_r     <= A_BASE;
      r_clr_pend_r <= 1'b0;
    end else begin
      r_state_r <= r_state_nxt_s;
      case (r_state_r)
        R_IDLE: begin
          r_beat_r <= {BCW{1'b0}};
          if (r_clr_eff_s) begin
            r_addr_r     <= A_BASE;
            r_clr_pend_r <= 1'b0;
          end
        end
        R_ADDR: begin
          if (rd_addr_clr) r_clr_pend_r <= 1'b1;
        end
        R_DATA: begin
          if (rd_addr_clr) r_clr_pend_r <= 1'b1;
          if (rd_valid) begin
            if (r_beat_r == B_LAST) begin
              r_beat_r <= {BCW{1'b0}};
              r_addr_r <= next_addr(r_addr_r);
            end else begin
              r_beat_r <= r_beat_r + BCW'(1);
            end
          end
        end
        default: r_beat_r <= {BCW{1'b0}};
      endcase
    end
  end

  assign rd_avalid   = (r_state_r == R_ADDR);
  assign rd_addr     = r_addr_r;
  assign rd_ready    = (r_state_r == R_DATA);
  assign rf_level    = rf_level_r;
  assign us_rd_valid = (rf_level_r != {RLW{1'b0}});
  assign us_rd_data  = rf_mem_r[rf_rp_r];

endmodule

// File: tb/tb_sdram_burst_fifo.sv
// Bench for sdram_burst_fifo: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a queue-based reference model.
module tb_sdram_burst_fifo;

  localparam int DW = 16, AW = 24, BL = 4, WFD = 16, RFD = 8;
  localparam int BASE = 0, LEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] us_wr_data = '0, us_rd_data, wr_data, rd_data = '0;
  logic us_wr_valid = 1'b0, us_wr_ready, us_rd_valid, us_rd_ready = 1'b0;
  logic rd_en = 1'b0, wr_addr_clr = 1'b0, rd_addr_clr = 1'b0;
  logic [AW-1:0] wr_addr, rd_addr;
  logic wr_valid, wr_ready = 1'b0, rd_avalid, rd_aready = 1'b0, rd_valid = 1'b0, rd_ready;
  logic [$clog2(WFD):0] wf_level;
  logic [$clog2(RFD):0] rf_level;

  sdram_burst_fifo #(.DW(DW), .AW(AW), .BL(BL), .WF_DEPTH(WFD), .RF_DEPTH(RFD),
                     .ADDR_BASE(BASE), .ADDR_LEN(LEN)) dut (
    .clk(clk), .rst(rst),
    .us_wr_data(us_wr_data), .us_wr_valid(us_wr_valid), .us_wr_ready(us_wr_ready),
    .us_rd_data(us_rd_data), .us_rd_valid(us_rd_valid), .us_rd_ready(us_rd_ready),
    .rd_en(rd_en), .wr_addr_clr(wr_addr_clr), .rd_addr_clr(rd_addr_clr),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_avalid(rd_avalid), .rd_aready(rd_aready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wf_level(wf_level), .rf_level(rf_level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] wq[$];
  logic [DW-1:0] rq[$];
  int  w_beats = 0, waddr = BASE, r_phase = 0, r_beats = 0, raddr = BASE;
  bit  w_busy = 0, wclr_pend = 0, rclr_pend = 0, m_wready = 0;

  // observed handshakes, for the literal checks
  int  wlog_addr[$];
  int  wlog_data[$];
  int  rlog_addr[$];
  logic prev_wr_valid = 1'b0, prev_rd_avalid = 1'b0;
  logic [AW-1:0] prev_wr_addr = '0, prev_rd_addr = '0;
  logic [DW-1:0] prev_wr_data = '0;

  function automatic int wrap_a(input int a);
    if (a + BL == BASE + LEN) return BASE;
    return a + BL;
  endfunction

  // Model update for the edge just passed (inputs are still held), then compare.
  always @(negedge clk) begin
    bit w_push, w_pop, r_push, r_pop, flush;
    if (!rst && prev_wr_valid && wr_ready) begin
      wlog_addr.push_back(int'(prev_wr_addr));
      wlog_data.push_back(int'(prev_wr_data));
    end
    if (!rst && prev_rd_avalid && rd_aready) rlog_addr.push_back(int'(prev_rd_addr));

    if (rst) begin
      wq.delete(); rq.delete();
      w_busy = 0; w_beats = 0; waddr = BASE; wclr_pend = 0; m_wready = 0;
      r_phase = 0; r_beats = 0; raddr = BASE; rclr_pend = 0;
    end else begin
      w_push = us_wr_valid && m_wready;
      w_pop  = w_busy && wr_ready;
      if (!w_busy) begin
        if (wclr_pend || wr_addr_clr) begin waddr = BASE; wclr_pend = 0; end
        else if (wq.size() >= BL) begin w_busy = 1; w_beats = 0; end
      end else begin
        if (wr_addr_clr) wclr_pend = 1;
        if (w_pop) begin
          w_beats++;
          if (w_beats == BL) begin waddr = wrap_a(waddr); w_busy = 0; end
        end
      end
      if (w_pop)  void'(wq.pop_front());
      if (w_push) wq.push_back(us_wr_data);
      m_wready = (wq.size() != WFD);

      r_pop  = (rq.size() > 0) && us_rd_ready;
      r_push = (r_phase == 2) && rd_valid;
      flush  = 0;
      case (r_phase)
        0: begin
          if (rclr_pend || rd_addr_clr) begin raddr = BASE; rclr_pend = 0; flush = 1; end
          else if (rd_en && (RFD - rq.size()) >= BL) r_phase = 1;
        end
        1: begin
          if (rd_addr_clr) rclr_pend = 1;
          if (rd_aready) begin r_phase = 2; r_beats = 0; end
        end
        default: begin
          if (rd_addr_clr) rclr_pend = 1;
          if (rd_valid) begin
            r_beats++;
            if (r_beats == BL) begin raddr = wrap_a(raddr); r_phase = 0; end
          end
        end
      endcase
      if (flush) rq.delete();
      else begin
        if (r_pop)  void'(rq.pop_front());
        if (r_push) rq.push_back(rd_data);
      end
    end

    chk("us_wr_ready", 32'(us_wr_ready), 32'(m_wready));
    chk("wr_valid",    32'(wr_valid),    32'(w_busy));
    chk("wf_level",    32'(wf_level),    32'(wq.size()));
    if (w_busy) begin
      chk("wr_addr", 32'(wr_addr), 32'(waddr));
      if (wq.size() > 0) chk("wr_data", 32'(wr_data), 32'(wq[0]));
    end
    chk("rd_avalid",   32'(rd_avalid),   32'(r_phase == 1));
    chk("rd_ready",    32'(rd_ready),    32'(r_phase == 2));
    if (r_phase == 1) chk("rd_addr", 32'(rd_addr), 32'(raddr));
    chk("rf_level",    32'(rf_level),    32'(rq.size()));
    chk("us_rd_valid", 32'(us_rd_valid), 32'(rq.size() > 0));
    if (rq.size() > 0) chk("us_rd_data", 32'(us_rd_data), 32'(rq[0]));

    prev_wr_valid  = wr_valid;  prev_wr_addr = wr_addr; prev_wr_data = wr_data;
    prev_rd_avalid = rd_avalid; prev_rd_addr = rd_addr;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
    rd_data = DW'($urandom);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_word(input int d);
    int guard;
    guard = 0;
    us_wr_valid = 1'b0;
    while (!us_wr_ready && guard < 200) begin step(); guard++; end
    if (guard == 200) chk("push_timeout", 32'd1, 32'd0);
    us_wr_valid = 1'b1;
    us_wr_data  = DW'(d);
    step();
    us_wr_valid = 1'b0;
  endtask

  initial begin
    // reset state
    step();
    chk("rst_us_wr_ready", 32'(us_wr_ready), 32'd0);
    chk("rst_wr_valid",    32'(wr_valid),    32'd0);
    chk("rst_wf_level",    32'(wf_level),    32'd0);
    steps(2);
    rst = 1'b0;
    step();
    chk("post_rst_us_wr_ready", 32'(us_wr_ready), 32'd1);

    // 36 words: bursts at 0,4,...,28 then wrap to 0
    wr_ready = 1'b1;
    for (int i = 1; i <= 36; i++) push_word(i);
    steps(20);
    chk("drain_wf_level", 32'(wf_level), 32'd0);
    // three more bursts bring the pointer to 0x10
    for (int i = 37; i <= 48; i++) push_word(i);
    steps(20);

    // burst at 0x10 held by wr_ready=0, then clear on beat 2
    wr_ready = 1'b0;
    for (int i = 49; i <= 52; i++) push_word(i);
    steps(3);
    wr_ready = 1'b1;
    step();
    wr_addr_clr = 1'b1;
    step();
    wr_addr_clr = 1'b0;
    steps(5);
    for (int i = 53; i <= 56; i++) push_word(i);
    steps(10);

    // rst on beat 2 of a burst at 0x04
    wr_ready = 1'b0;
    for (int i = 57; i <= 60; i++) push_word(i);
    steps(3);
    wr_ready = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_mid_wf_level", 32'(wf_level), 32'd0);
    step();
    for (int i = 61; i <= 64; i++) push_word(i);
    steps(10);

    // literal pins on the observed write beats
    chk("wlog_size", 32'(wlog_addr.size()), 32'd61);
    if (wlog_addr.size() == 61) begin
      chk("b0_addr",  32'(wlog_addr[0]),  32'h00); chk("b0_data",  32'(wlog_data[0]),  32'd1);
      chk("b3_data",  32'(wlog_data[3]),  32'd4);
      chk("b4_addr",  32'(wlog_addr[4]),  32'h04); chk("b4_data",  32'(wlog_data[4]),  32'd5);
      chk("b31_addr", 32'(wlog_addr[31]), 32'h1C); chk("b31_data", 32'(wlog_data[31]), 32'd32);
      chk("b32_addr", 32'(wlog_addr[32]), 32'h00); chk("b32_data", 32'(wlog_data[32]), 32'd33);
      chk("b48_addr", 32'(wlog_addr[48]), 32'h10); chk("b51_addr", 32'(wlog_addr[51]), 32'h10);
      chk("b51_data", 32'(wlog_data[51]), 32'd52);
      chk("b52_addr", 32'(wlog_addr[52]), 32'h00); chk("b52_data", 32'(wlog_data[52]), 32'd53);
      chk("b56_addr", 32'(wlog_addr[56]), 32'h04); chk("b56_data", 32'(wlog_data[56]), 32'd57);
      chk("b57_addr", 32'(wlog_addr[57]), 32'h00); chk("b57_data", 32'(wlog_data[57]), 32'd61);
    end

    // read prefetch with the user stalled: exactly two bursts fill the FIFO
    rd_en = 1'b1; rd_aready = 1'b1; rd_valid = 1'b1; us_rd_ready = 1'b0;
    steps(40);
    chk("rd_fill_level", 32'(rf_level), 32'd8);
    chk("rd_bursts_2",   32'(rlog_addr.size()), 32'd2);
    if (rlog_addr.size() >= 2) begin
      chk("rd_addr0", 32'(rlog_addr[0]), 32'h00);
      chk("rd_addr1", 32'(rlog_addr[1]), 32'h04);
    end
    us_rd_ready = 1'b1;
    steps(4);
    us_rd_ready = 1'b0;
    steps(30);
    chk("rd_bursts_3", 32'(rlog_addr.size()), 32'd3);
    if (rlog_addr.size() >= 3) chk("rd_addr2", 32'(rlog_addr[2]), 32'h08);
    chk("rd_refill_level", 32'(rf_level), 32'd8);

    // randomized traffic; the model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 499) == 0);
      us_wr_valid = ($urandom_range(0, 9) < 6);
      us_wr_data  = DW'($urandom);
      wr_ready    = ($urandom_range(0, 9) < 7);
      us_rd_ready = ($urandom_range(0, 9) < 5);
      rd_aready   = ($urandom_range(0, 9) < 6);
      rd_valid    = ($urandom_range(0, 9) < 7);
      rd_en       = ($urandom_range(0, 9) < 9);
      wr_addr_clr = ($urandom_range(0, 39) == 0);
      rd_addr_clr = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
